// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse capture bank: channel FSM encoding,
// readback select base and status word layout.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2
    } cap_state_t;

    localparam logic [4:0] SEL_BASE  = 5'b10000;
    localparam int         VALID_LSB = 0;
    localparam int         OVF_LSB   = 16;

    // True when a select code addresses one of the nch capture channels.
    function automatic logic sel_in_range(input logic [4:0] code, input int nch);
        logic [4:0] offs;
        offs = code - SEL_BASE;
        return (code >= SEL_BASE) && (int'(offs) < nch);
    endfunction

endpackage

// File: rtl/pulse_capture_measure.sv
// One capture channel: input synchronizer, edge detect, IDLE/ARMED/HIGH FSM,
// saturating counter and latched delay/width results.
module pulse_measure
    import pulse_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pulse_in,
    input  logic             en,
    input  logic             pol,
    output logic [CNT_W-1:0] delay_res,
    output logic [CNT_W-1:0] width_res,
    output logic             done,
    output logic             done_ovf
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s, s_d_reg, rise, fall;
    cap_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;
    logic [CNT_W-1:0]       pend_reg, pend_next;
    logic [CNT_W-1:0]       delay_reg, delay_next, width_reg, width_next;
    logic                   sat_reg, sat_next, cnt_max;

    assign s       = sync_reg[SYNC_STAGES-1] ^ pol;
    assign rise    = s & ~s_d_reg;
    assign fall    = ~s & s_d_reg;
    assign cnt_max = &cnt_reg;
    assign cnt_inc = cnt_max ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg  <= '0;
            s_d_reg   <= 1'b0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            delay_reg <= '0;
            width_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pulse_in};
            s_d_reg   <= s;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            delay_reg <= delay_next;
            width_reg <= width_next;
            sat_reg   <= sat_next;
        end
    end

    // Saturation is flagged only when an increment is lost at all-ones.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        delay_next = delay_reg;
        width_next = width_reg;
        sat_next   = sat_reg;
        done       = 1'b0;
        done_ovf   = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_ARMED;
                        cnt_next   = '0;
                        sat_next   = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (start) begin
                        cnt_next = '0;
                        sat_next = 1'b0;
                    end else if (rise) begin
                        state_next = ST_HIGH;
                        pend_next  = cnt_inc;
                        sat_next   = sat_reg | cnt_max;
                        cnt_next   = CNT_ONE;
                    end else begin
                        cnt_next = cnt_inc;
                        sat_next = sat_reg | cnt_max;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_next = ST_IDLE;
                        delay_next = pend_reg;
                        width_next = cnt_reg;
                        done       = 1'b1;
                        done_ovf   = sat_reg;
                    end else if (s) begin
                        cnt_next = cnt_inc;
                        sat_next = sat_reg | cnt_max;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign delay_res = delay_reg;
    assign width_res = width_reg;

endmodule

// File: rtl/pulse_capture.sv
// Bank of NCH pulse capture channels with valid/overflow bookkeeping,
// select-register readback, status word and interrupt.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int NCH         = 14,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   pulse_in,
    input  logic [31:0]      CaptureEnables_reg,
    input  logic [31:0]      CapturePolarity_reg,
    input  logic [31:0]      CaptureSelect_reg,
    input  logic [31:0]      CaptureClear_reg,
    output logic [CNT_W-1:0] CaptureDelay_reg,
    output logic [CNT_W-1:0] CaptureWidth_reg,
    output logic [31:0]      CaptureStatus_reg,
    output logic             capture_irq
);

    logic [CNT_W-1:0] delay_res [NCH];
    logic [CNT_W-1:0] width_res [NCH];
    logic [NCH-1:0]   done, done_ovf;
    logic [NCH-1:0]   valid_reg, valid_next, ovf_reg, ovf_next;
    logic [31:0]      status_next;
    logic [4:0]       sel_offs;
    logic [3:0]       sel_idx;
    logic             sel_hit;
    logic             unused_bits;

    // A completion in the same cycle as a clear takes precedence.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            pulse_measure #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_measure (
                .clk       (clk),
                .reset     (reset),
                .start     (start[gi]),
                .pulse_in  (pulse_in[gi]),
                .en        (CaptureEnables_reg[gi]),
                .pol       (CapturePolarity_reg[gi]),
                .delay_res (delay_res[gi]),
                .width_res (width_res[gi]),
                .done      (done[gi]),
                .done_ovf  (done_ovf[gi])
            );
            assign valid_next[gi] = done[gi] | (valid_reg[gi] & ~CaptureClear_reg[gi]);
            assign ovf_next[gi]   = (done[gi] & done_ovf[gi]) | (ovf_reg[gi] & ~CaptureClear_reg[gi]);
        end
    endgenerate

    assign sel_offs = CaptureSelect_reg[4:0] - SEL_BASE;
    assign sel_idx  = sel_offs[3:0];
    assign sel_hit  = sel_in_range(CaptureSelect_reg[4:0], NCH);

    always_comb begin
        status_next                    = '0;
        status_next[VALID_LSB +: NCH]  = valid_reg;
        status_next[OVF_LSB +: NCH]    = ovf_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg         <= '0;
            ovf_reg           <= '0;
            CaptureDelay_reg  <= '0;
            CaptureWidth_reg  <= '0;
            CaptureStatus_reg <= '0;
            capture_irq       <= 1'b0;
        end else begin
            valid_reg         <= valid_next;
            ovf_reg           <= ovf_next;
            CaptureStatus_reg <= status_next;
            capture_irq       <= |(valid_reg & CaptureEnables_reg[NCH-1:0]);
            if (sel_hit) begin
                CaptureDelay_reg <= delay_res[sel_idx];
                CaptureWidth_reg <= width_res[sel_idx];
            end
        end
    end

    assign unused_bits = ^{CaptureEnables_reg[31:NCH], CapturePolarity_reg[31:NCH],
                           CaptureClear_reg[31:NCH], CaptureSelect_reg[31:5], sel_offs[4]};

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: vector table, randomized pulses against
// an edge-arithmetic model, and hand sequences for multi-cycle corner cases.
`timescale 1ns/1ps
module tb_pulse_capture;

    localparam int NCH    = 14;
    localparam int CNT_W  = 32;
    localparam int SS     = 2;
    localparam int SNCH   = 4;
    localparam int SCNT_W = 8;
    localparam int SMAX   = (1 << SCNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   start, pulse_in;
    logic [31:0]      en, pol, sel, clr;
    logic [CNT_W-1:0] delay_o, width_o;
    logic [31:0]      status_o;
    logic             irq;

    logic [SNCH-1:0]   s_start, s_pulse;
    logic [31:0]       s_en, s_pol, s_sel, s_clr;
    logic [SCNT_W-1:0] s_delay, s_width;
    logic [31:0]       s_status;
    logic              s_irq;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int ch; int pol; int d0; int w; int regap; int hi_start; int exp_d; int exp_w;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_capture #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in),
        .CaptureEnables_reg(en), .CapturePolarity_reg(pol),
        .CaptureSelect_reg(sel), .CaptureClear_reg(clr),
        .CaptureDelay_reg(delay_o), .CaptureWidth_reg(width_o),
        .CaptureStatus_reg(status_o), .capture_irq(irq)
    );

    pulse_capture #(.NCH(SNCH), .CNT_W(SCNT_W), .SYNC_STAGES(SS)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .pulse_in(s_pulse),
        .CaptureEnables_reg(s_en), .CapturePolarity_reg(s_pol),
        .CaptureSelect_reg(s_sel), .CaptureClear_reg(s_clr),
        .CaptureDelay_reg(s_delay), .CaptureWidth_reg(s_width),
        .CaptureStatus_reg(s_status), .capture_irq(s_irq)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_start(input bit sm, input int ch, input logic v);
        if (sm) s_start[ch] = v;
        else    start[ch]   = v;
    endtask

    task automatic drive_active(input bit sm, input int ch, input logic act);
        if (sm) s_pulse[ch]  = act ^ s_pol[ch];
        else    pulse_in[ch] = act ^ pol[ch];
    endtask

    // Model: delay = first active sample edge - last arming start edge + SS,
    // width = number of active sample edges; starts during the pulse are ignored.
    task automatic run_pulse(input bit sm, input int ch, input int d0, input int w,
                             input int regap, input int hi_start,
                             output int exp_d, output int exp_w);
        int st, fa, n;
        drive_start(sm, ch, 1'b1); tick(); st = cyc; drive_start(sm, ch, 1'b0);
        if (regap > 0) begin
            tick(regap - 1);
            drive_start(sm, ch, 1'b1); tick(); st = cyc; drive_start(sm, ch, 1'b0);
        end
        tick(d0 - 1);
        drive_active(sm, ch, 1'b1);
        n  = 0;
        fa = 0;
        for (int k = 0; k < w; k++) begin
            if (k == hi_start) drive_start(sm, ch, 1'b1);
            tick();
            drive_start(sm, ch, 1'b0);
            if (k == 0) fa = cyc;
            n++;
        end
        drive_active(sm, ch, 1'b0);
        tick(SS + 2);
        exp_d = fa - st + SS;
        exp_w = n;
    endtask

    task automatic read_ch(input bit sm, input int ch, output logic [31:0] d, output logic [31:0] w);
        if (sm) s_sel = 32'(16 + ch);
        else    sel   = 32'(16 + ch);
        tick();
        if (sm) begin
            d = 32'(s_delay);
            w = 32'(s_width);
        end else begin
            d = delay_o;
            w = width_o;
        end
    endtask

    task automatic clear_ch(input bit sm, input int ch);
        if (sm) s_clr[ch] = 1'b1;
        else    clr[ch]   = 1'b1;
        tick();
        if (sm) s_clr = '0;
        else    clr   = '0;
        tick();
    endtask

    task automatic set_pol(input bit sm, input int ch, input logic p);
        if (sm) begin
            s_pol[ch] = p; s_pulse[ch] = p;
        end else begin
            pol[ch] = p; pulse_in[ch] = p;
        end
        tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ed, ew, ch, p, d0, wd, rg, hs;
        logic [31:0] d, w;

        reset = 1'b1;
        start = '0; pulse_in = '0; en = '0; pol = '0; sel = '0; clr = '0;
        s_start = '0; s_pulse = '0; s_en = '0; s_pol = '0; s_sel = '0; s_clr = '0;
        tick(3);
        check("reset_delay", delay_o, 0);
        check("reset_width", width_o, 0);
        check("reset_status", status_o, 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_small_status", s_status, 0);
        reset = 1'b0;
        en    = 32'h0000_3FFF;
        s_en  = 32'h0000_000F;
        tick(4);

        vecs[0] = '{0, 0, 10, 5, 0, -1, 12, 5};
        vecs[1] = '{3, 1, 20, 8, 0, -1, 22, 8};
        vecs[2] = '{7, 0, 1, 1, 0, -1, 3, 1};
        vecs[3] = '{13, 1, 5, 3, 4, -1, 7, 3};
        vecs[4] = '{4, 0, 6, 8, 0, 4, 8, 8};
        vecs[5] = '{2, 0, 30, 17, 0, -1, 32, 17};
        for (int i = 0; i < 6; i++) begin
            set_pol(1'b0, vecs[i].ch, vecs[i].pol[0]);
            run_pulse(1'b0, vecs[i].ch, vecs[i].d0, vecs[i].w, vecs[i].regap, vecs[i].hi_start, ed, ew);
            read_ch(1'b0, vecs[i].ch, d, w);
            $display("txn table %0d ch=%0d delay=%0d width=%0d status=0x%08h", i, vecs[i].ch, d, w, status_o);
            check("tbl_delay", d, vecs[i].exp_d);
            check("tbl_width", w, vecs[i].exp_w);
            check("tbl_valid", 32'(status_o[vecs[i].ch]), 1);
            check("tbl_ovf", 32'(status_o[16 + vecs[i].ch]), 0);
            check("tbl_irq", 32'(irq), 1);
            clear_ch(1'b0, vecs[i].ch);
            check("tbl_irq_after_clear", 32'(irq), 0);
        end

        for (int r = 0; r < 20; r++) begin
            ch = int'($urandom_range(NCH - 1, 0));
            p  = int'($urandom_range(1, 0));
            d0 = int'($urandom_range(40, 1));
            wd = int'($urandom_range(25, 1));
            rg = ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 1)) : 0;
            hs = (wd >= 5 && $urandom_range(1, 0) == 1) ? int'($urandom_range(wd - 1, 3)) : -1;
            set_pol(1'b0, ch, p[0]);
            run_pulse(1'b0, ch, d0, wd, rg, hs, ed, ew);
            read_ch(1'b0, ch, d, w);
            $display("txn rand %0d ch=%0d pol=%0d delay=%0d/%0d width=%0d/%0d", r, ch, p, d, ed, w, ew);
            check("rand_delay", d, 32'(ed));
            check("rand_width", w, 32'(ew));
            check("rand_valid", 32'(status_o[ch]), 1);
            clear_ch(1'b0, ch);
            check("rand_valid_cleared", 32'(status_o[ch]), 0);
        end

        // Rise while idle, then a rise coinciding with the arming start.
        set_pol(1'b0, 6, 1'b0);
        drive_active(1'b0, 6, 1'b1); tick(3); drive_active(1'b0, 6, 1'b0); tick(6);
        $display("txn idle_rise ch=6 status=0x%08h", status_o);
        check("idle_rise_valid", 32'(status_o[6]), 0);
        drive_active(1'b0, 6, 1'b1); tick(2);
        drive_start(1'b0, 6, 1'b1); tick(); drive_start(1'b0, 6, 1'b0);
        tick(4); drive_active(1'b0, 6, 1'b0); tick(6);
        $display("txn same_cycle_rise ch=6 status=0x%08h", status_o);
        check("same_cycle_rise_valid", 32'(status_o[6]), 0);
        check("same_cycle_rise_irq", 32'(irq), 0);
        en[6] = 1'b0; tick(); en[6] = 1'b1; tick();

        // Disable during HIGH keeps the previous result.
        set_pol(1'b0, 5, 1'b0);
        run_pulse(1'b0, 5, 5, 4, 0, -1, ed, ew);
        drive_start(1'b0, 5, 1'b1); tick(); drive_start(1'b0, 5, 1'b0); tick(2);
        drive_active(1'b0, 5, 1'b1); tick(5);
        en[5] = 1'b0; tick();
        drive_active(1'b0, 5, 1'b0); tick(6);
        read_ch(1'b0, 5, d, w);
        $display("txn disable ch=5 delay=%0d width=%0d status=0x%08h", d, w, status_o);
        check("disable_delay", d, 7);
        check("disable_width", w, 4);
        check("disable_valid", 32'(status_o[5]), 1);
        check("disable_irq_masked", 32'(irq), 0);
        en[5] = 1'b1; tick();
        check("reenable_irq", 32'(irq), 1);
        run_pulse(1'b0, 5, 9, 6, 0, -1, ed, ew);
        read_ch(1'b0, 5, d, w);
        $display("txn reenable ch=5 delay=%0d width=%0d", d, w);
        check("reenable_delay", d, 11);
        check("reenable_width", w, 6);
        clear_ch(1'b0, 5);

        // Clear strobe on the completion edge, then clear alone.
        set_pol(1'b0, 1, 1'b0);
        drive_start(1'b0, 1, 1'b1); tick(); drive_start(1'b0, 1, 1'b0);
        tick(3);
        drive_active(1'b0, 1, 1'b1); tick(3); drive_active(1'b0, 1, 1'b0);
        tick(SS);
        clr[1] = 1'b1; tick(); clr[1] = 1'b0;
        tick();
        $display("txn clear_vs_done ch=1 status=0x%08h irq=%0d", status_o, irq);
        check("clr_vs_done_valid", 32'(status_o[1]), 1);
        check("clr_vs_done_irq", 32'(irq), 1);
        clear_ch(1'b0, 1);
        check("clr_alone_valid", 32'(status_o[1]), 0);
        check("clr_alone_irq", 32'(irq), 0);
        read_ch(1'b0, 1, d, w);
        check("ch1_delay", d, 6);
        check("ch1_width", w, 3);
        sel = 32'h0000_000F; tick(2);
        $display("txn hold sel=0x0f delay=%0d width=%0d", delay_o, width_o);
        check("hold_01111_delay", delay_o, 6);
        check("hold_01111_width", width_o, 3);
        sel = 32'h0000_001E; tick(2);
        check("hold_oob_delay", delay_o, 6);
        check("hold_oob_width", width_o, 3);

        // Saturation on the 8-bit build.
        run_pulse(1'b1, 2, 3, 300, 0, -1, ed, ew);
        read_ch(1'b1, 2, d, w);
        $display("txn sat_width ch=2 delay=%0d width=%0d status=0x%08h", d, w, s_status);
        check("sat_delay", d, 32'((ed > SMAX) ? SMAX : ed));
        check("sat_width", w, 32'((ew > SMAX) ? SMAX : ew));
        check("sat_ovf", 32'(s_status[18]), 1);
        check("sat_valid", 32'(s_status[2]), 1);
        check("sat_irq", 32'(s_irq), 1);
        clear_ch(1'b1, 2);
        check("sat_ovf_cleared", 32'(s_status[18]), 0);
        run_pulse(1'b1, 2, 7, 10, 0, -1, ed, ew);
        read_ch(1'b1, 2, d, w);
        $display("txn sat_normal ch=2 delay=%0d width=%0d status=0x%08h", d, w, s_status);
        check("post_sat_delay", d, 32'(ed));
        check("post_sat_width", w, 32'(ew));
        check("post_sat_ovf", 32'(s_status[18]), 0);
        run_pulse(1'b1, 2, 253, 255, 0, -1, ed, ew);
        read_ch(1'b1, 2, d, w);
        $display("txn sat_edge ch=2 delay=%0d width=%0d status=0x%08h", d, w, s_status);
        check("max_exact_delay", d, 32'(ed));
        check("max_exact_width", w, 32'(ew));
        check("max_exact_ovf", 32'(s_status[18]), 32'((ed > SMAX || ew > SMAX) ? 1 : 0));
        run_pulse(1'b1, 1, 300, 4, 0, -1, ed, ew);
        read_ch(1'b1, 1, d, w);
        $display("txn sat_delay ch=1 delay=%0d width=%0d status=0x%08h", d, w, s_status);
        check("sat_armed_delay", d, 32'((ed > SMAX) ? SMAX : ed));
        check("sat_armed_width", w, 32'(ew));
        check("sat_armed_ovf", 32'(s_status[17]), 1);
        s_sel = 32'h0000_000F; tick(2);
        check("small_hold_delay", 32'(s_delay), 32'(SMAX));
        check("small_hold_width", 32'(s_width), 32'(ew));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
